// File: rtl/fb_write_queue_if.sv
// Bus bundle for fb_write_queue: CDC-side write pulses, scanout busy flag,
// RAM write port and status. The master drives the queue; the slave is the queue.
interface fb_write_queue_if #(
    parameter int FIFO_AW = 4,
    parameter int AW      = 12,
    parameter int DW      = 12
);
    logic [AW-1:0]      in_addr;
    logic [DW-1:0]      in_data;
    logic               in_we;
    logic               vid_busy;
    logic               ovf_clr;
    logic [AW-1:0]      ram_addr;
    logic [DW-1:0]      ram_wdata;
    logic               ram_we;
    logic [FIFO_AW:0]   fifo_level;
    logic               overflow;

    modport master (
        output in_addr, in_data, in_we, vid_busy, ovf_clr,
        input  ram_addr, ram_wdata, ram_we, fifo_level, overflow
    );

    modport slave (
        input  in_addr, in_data, in_we, vid_busy, ovf_clr,
        output ram_addr, ram_wdata, ram_we, fifo_level, overflow
    );
endinterface

// File: rtl/fb_write_queue.sv
// Pixel-domain write queue: buffers CDC write pulses and issues them to the frame
// buffer RAM only when scanout does not own the port. FBWQ_STATS_EN adds drop_cnt/hwm.
//
// state | meaning
// IDLE  | waiting for a queued entry and a free RAM port
// WRITE | ram_we high for the entry just popped
// GAP   | forced idle cycles after a write (WR_GAP of them)
module fb_write_queue #(
    parameter int FIFO_AW = 4,
    parameter int AW      = 12,
    parameter int DW      = 12,
    parameter int WR_GAP  = 1
) (
    input  logic                clk_pixel,
    input  logic                rst_pixel_n,
    fb_write_queue_if.slave     bus
`ifdef FBWQ_STATS_EN
    ,
    output logic [15:0]         drop_cnt,
    output logic [FIFO_AW:0]    hwm
`endif
);
    localparam int DEPTH = 2**FIFO_AW;
    localparam logic [2:0] GAP_LOAD = (WR_GAP == 0) ? 3'd0 : 3'(WR_GAP - 1);

    typedef enum logic [1:0] {IDLE, WRITE, GAP} state_t;

    state_t              state, state_nxt;
    logic [2:0]          gap_cnt, gap_cnt_nxt;
    logic [AW+DW-1:0]    mem [DEPTH];
    logic [AW+DW-1:0]    head;
    logic [FIFO_AW:0]    wr_ptr, rd_ptr, wr_ptr_nxt, rd_ptr_nxt;
    logic                empty, full, pop, push, drop, ram_we_nxt;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[FIFO_AW] != rd_ptr[FIFO_AW]) &&
                   (wr_ptr[FIFO_AW-1:0] == rd_ptr[FIFO_AW-1:0]);
    assign head  = mem[rd_ptr[FIFO_AW-1:0]];

    // A push into a full FIFO survives when the head leaves in the same cycle.
    assign push = bus.in_we && (!full || pop);
    assign drop = bus.in_we && full && !pop;

    assign wr_ptr_nxt     = push ? wr_ptr + 1'b1 : wr_ptr;
    assign rd_ptr_nxt     = pop  ? rd_ptr + 1'b1 : rd_ptr;
    assign bus.fifo_level = wr_ptr - rd_ptr;

    always_comb begin
        state_nxt   = state;
        gap_cnt_nxt = gap_cnt;
        pop         = 1'b0;
        ram_we_nxt  = 1'b0;
        case (state)
            IDLE: begin
                if (!empty && !bus.vid_busy) begin
                    pop        = 1'b1;
                    ram_we_nxt = 1'b1;
                    state_nxt  = WRITE;
                end
            end
            WRITE: begin
                if (WR_GAP == 0) begin
                    state_nxt = IDLE;
                end else begin
                    state_nxt   = GAP;
                    gap_cnt_nxt = GAP_LOAD;
                end
            end
            GAP: begin
                if (gap_cnt == 3'd0) state_nxt = IDLE;
                else                 gap_cnt_nxt = gap_cnt - 1'b1;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_pixel or negedge rst_pixel_n) begin
        if (!rst_pixel_n) begin
            state   <= IDLE;
            gap_cnt <= 3'd0;
        end else begin
            state   <= state_nxt;
            gap_cnt <= gap_cnt_nxt;
        end
    end

    always_ff @(posedge clk_pixel or negedge rst_pixel_n) begin
        if (!rst_pixel_n) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            bus.ram_addr  <= '0;
            bus.ram_wdata <= '0;
            bus.ram_we    <= 1'b0;
            bus.overflow  <= 1'b0;
        end else begin
            wr_ptr     <= wr_ptr_nxt;
            rd_ptr     <= rd_ptr_nxt;
            bus.ram_we <= ram_we_nxt;
            if (pop) {bus.ram_addr, bus.ram_wdata} <= head;
            if (drop)             bus.overflow <= 1'b1;
            else if (bus.ovf_clr) bus.overflow <= 1'b0;
        end
    end

    always_ff @(posedge clk_pixel) begin
        if (push) mem[wr_ptr[FIFO_AW-1:0]] <= {bus.in_addr, bus.in_data};
    end

`ifdef FBWQ_STATS_EN
    logic [FIFO_AW:0] level_nxt;
    assign level_nxt = wr_ptr_nxt - rd_ptr_nxt;

    always_ff @(posedge clk_pixel or negedge rst_pixel_n) begin
        if (!rst_pixel_n) begin
            drop_cnt <= 16'd0;
            hwm      <= '0;
        end else begin
            if (bus.ovf_clr)
                drop_cnt <= drop ? 16'd1 : 16'd0;
            else if (drop && drop_cnt != 16'hFFFF)
                drop_cnt <= drop_cnt + 1'b1;
            if (level_nxt > hwm) hwm <= level_nxt;
        end
    end
`endif
endmodule

// File: tb/tb_fb_write_queue.sv
// Randomized bench for fb_write_queue against a queue-based model of the spec:
// a write may issue at an edge when the queue is non-empty, vid_busy is low and
// at least 2+WR_GAP edges have passed since the previous issue.
module tb_fb_write_queue;
    localparam int FIFO_AW = 4;
    localparam int AW      = 12;
    localparam int DW      = 12;
    localparam int WR_GAP  = 1;
    localparam int DEPTH   = 2**FIFO_AW;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    fb_write_queue_if #(.FIFO_AW(FIFO_AW), .AW(AW), .DW(DW)) bus ();

`ifdef FBWQ_STATS_EN
    logic [15:0]      drop_cnt;
    logic [FIFO_AW:0] hwm;
`endif

    fb_write_queue #(.FIFO_AW(FIFO_AW), .AW(AW), .DW(DW), .WR_GAP(WR_GAP)) dut (
        .clk_pixel   (clk),
        .rst_pixel_n (rst_n),
        .bus         (bus)
`ifdef FBWQ_STATS_EN
        ,
        .drop_cnt    (drop_cnt),
        .hwm         (hwm)
`endif
    );

    int n_vec = 0;
    int n_err = 0;

    logic [AW+DW-1:0] q[$];
    int               cyc     = 0;
    int               next_ok = 0;
    logic             exp_we   = 1'b0;
    logic [AW-1:0]    exp_addr = '0;
    logic [DW-1:0]    exp_data = '0;
    logic             exp_ovf  = 1'b0;
    int               exp_drop = 0;
    int               exp_hwm  = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        next_ok  = 0;
        exp_we   = 1'b0;
        exp_addr = '0;
        exp_data = '0;
        exp_ovf  = 1'b0;
        exp_drop = 0;
        exp_hwm  = 0;
    endtask

    // One clock edge: predict from current inputs, advance, then compare.
    task automatic step();
        bit m_full, m_pop, m_drop;
        m_full = (q.size() == DEPTH);
        m_pop  = (q.size() != 0) && !bus.vid_busy && (cyc >= next_ok);
        m_drop = bus.in_we && m_full && !m_pop;
        if (m_pop) begin
            {exp_addr, exp_data} = q.pop_front();
            exp_we  = 1'b1;
            next_ok = cyc + 2 + WR_GAP;
        end else begin
            exp_we = 1'b0;
        end
        if (bus.in_we && !m_drop) q.push_back({bus.in_addr, bus.in_data});
        if (m_drop)           exp_ovf = 1'b1;
        else if (bus.ovf_clr) exp_ovf = 1'b0;
        if (bus.ovf_clr)                    exp_drop = m_drop ? 1 : 0;
        else if (m_drop && exp_drop < 65535) exp_drop++;
        if (q.size() > exp_hwm) exp_hwm = q.size();

        @(posedge clk);
        #1;
        cyc++;
        check_val("ram_we",     {31'd0, bus.ram_we}, {31'd0, exp_we});
        check_val("ram_addr",   32'(bus.ram_addr),   32'(exp_addr));
        check_val("ram_wdata",  32'(bus.ram_wdata),  32'(exp_data));
        check_val("fifo_level", 32'(bus.fifo_level), q.size());
        check_val("overflow",   {31'd0, bus.overflow}, {31'd0, exp_ovf});
`ifdef FBWQ_STATS_EN
        check_val("drop_cnt", 32'(drop_cnt), exp_drop);
        check_val("hwm",      32'(hwm),      exp_hwm);
`endif
    endtask

    task automatic push(input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus.in_addr = a;
        bus.in_data = d;
        bus.in_we   = 1'b1;
        step();
        bus.in_we   = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n        = 1'b0;
        bus.in_addr  = '0;
        bus.in_data  = '0;
        bus.in_we    = 1'b0;
        bus.vid_busy = 1'b0;
        bus.ovf_clr  = 1'b0;
        #12;
        check_val("rst_ram_we",   {31'd0, bus.ram_we},   32'd0);
        check_val("rst_level",    32'(bus.fifo_level),   32'd0);
        check_val("rst_overflow", {31'd0, bus.overflow}, 32'd0);
        check_val("rst_ram_addr", 32'(bus.ram_addr),     32'd0);
        rst_n = 1'b1;
        model_reset();

        // single write, two edges of latency
        push(12'h123, 12'hABC);
        step();
        check_val("single_we",   {31'd0, bus.ram_we}, 32'd1);
        check_val("single_addr", 32'(bus.ram_addr),   32'h123);
        check_val("single_data", 32'(bus.ram_wdata),  32'hABC);
        idle(5);
        check_val("single_level", 32'(bus.fifo_level), 32'd0);

        // busy stall then ordered drain
        bus.vid_busy = 1'b1;
        for (int i = 1; i <= 5; i++) push(AW'(i), DW'(i * 7));
        idle(3);
        check_val("stall_level", 32'(bus.fifo_level), 32'd5);
        bus.vid_busy = 1'b0;
        idle(20);

        // overflow: 18 pushes into 16 entries, then clear
        bus.vid_busy = 1'b1;
        for (int i = 0; i < 18; i++) push(AW'(12'h200 + i), DW'(12'h800 + i));
        check_val("ovf_level", 32'(bus.fifo_level),   32'd16);
        check_val("ovf_set",   {31'd0, bus.overflow}, 32'd1);
        bus.ovf_clr = 1'b1;
        step();
        bus.ovf_clr = 1'b0;
        check_val("ovf_clr", {31'd0, bus.overflow}, 32'd0);

        // full push with simultaneous pop, then drain all 17
        bus.vid_busy = 1'b0;
        push(12'h3FF, 12'h555);
        check_val("fullpp_level", 32'(bus.fifo_level),   32'd16);
        check_val("fullpp_ovf",   {31'd0, bus.overflow}, 32'd0);
        idle(60);

        // reset during a WRITE cycle
        bus.vid_busy = 1'b1;
        for (int i = 0; i < 8; i++) push(AW'(12'h400 + i), DW'(12'h100 + i));
        bus.vid_busy = 1'b0;
        for (int i = 0; i < 10 && !exp_we; i++) step();
        check_val("pre_rst_we", {31'd0, bus.ram_we}, 32'd1);
        #1 rst_n = 1'b0;
        #1;
        check_val("mid_rst_we",    {31'd0, bus.ram_we},   32'd0);
        check_val("mid_rst_level", 32'(bus.fifo_level),   32'd0);
        check_val("mid_rst_ovf",   {31'd0, bus.overflow}, 32'd0);
        #2 rst_n = 1'b1;
        model_reset();
        idle(10);

        // randomized traffic with toggling vid_busy
        for (int i = 0; i < 500; i++) begin
            bus.vid_busy = 1'($urandom_range(0, 1));
            bus.in_we    = ($urandom_range(0, 3) == 0);
            bus.in_addr  = AW'($urandom);
            bus.in_data  = DW'($urandom);
            bus.ovf_clr  = ($urandom_range(0, 63) == 0);
            step();
        end
        bus.in_we    = 1'b0;
        bus.ovf_clr  = 1'b0;
        bus.vid_busy = 1'b0;
        idle(60);
        check_val("final_level", 32'(bus.fifo_level), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
